// File: rtl/lcd_display_driver.sv
// lcd_display_driver
// Display and alarm-compare stage of the alarm clock. It selects one BCD digit
// from the keypad entry, the stored alarm time or the running time, and drives
// the LCD with that digit's ASCII code. A non-BCD digit is shown as ERR_CHAR.
// sound_alarm is raised when the alarm digit equals the current-time digit and
// is a valid BCD value. Both outputs are registered with one cycle of latency.
module lcd_display_driver #(
  parameter int                DIGIT_W  = 4,
  parameter int                CHAR_W   = 8,
  parameter logic [CHAR_W-1:0] ERR_CHAR = 8'h45,
  parameter logic [CHAR_W-1:0] RST_CHAR = 8'h20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] key,
  input  logic [DIGIT_W-1:0] alarm_time,
  input  logic [DIGIT_W-1:0] current_time,
  input  logic               show_alarm,
  input  logic               show_new_time,
  output logic [CHAR_W-1:0]  display_time,
  output logic               sound_alarm
);

  localparam logic [DIGIT_W-1:0] MAX_BCD    = DIGIT_W'(9);
  localparam logic [CHAR_W-1:0]  ASCII_ZERO = CHAR_W'(8'h30);

  logic [DIGIT_W-1:0] digit_sel;
  logic [CHAR_W-1:0]  disp_char_c;
  logic               alarm_hit_c;
  logic [CHAR_W-1:0]  disp_char_p0;
  logic               alarm_hit_p0;

  // Digits 0..9 map onto '0'..'9'; anything above 9 is shown as ERR_CHAR.
  function automatic logic [CHAR_W-1:0] decode_digit(input logic [DIGIT_W-1:0] d);
    logic [CHAR_W-1:0] ch;
    if (d <= MAX_BCD) begin
      ch = ASCII_ZERO + CHAR_W'(d);
    end else begin
      ch = ERR_CHAR;
    end
    return ch;
  endfunction

  // Stage 0 input: select source (keypad entry has priority), decode it, and
  // compare alarm against current time.
  always_comb begin
    digit_sel = current_time;
    if (show_new_time) begin
      digit_sel = key;
    end else if (show_alarm) begin
      digit_sel = alarm_time;
    end
    disp_char_c = decode_digit(digit_sel);
    alarm_hit_c = (alarm_time == current_time) && (alarm_time <= MAX_BCD);
  end

  // Stage 0 register: output flops; reset blanks the LCD and silences the buzzer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp_char_p0 <= RST_CHAR;
      alarm_hit_p0 <= 1'b0;
    end else begin
      disp_char_p0 <= disp_char_c;
      alarm_hit_p0 <= alarm_hit_c;
    end
  end

  assign display_time = disp_char_p0;
  assign sound_alarm  = alarm_hit_p0;

endmodule

// File: tb/tb_lcd_display_driver.sv
// Testbench for lcd_display_driver: directed cases plus random stimulus,
// checked through a scoreboard queue fed by a behavioural model.
module tb_lcd_display_driver;

  typedef struct {
    string      name;
    logic [7:0] disp;
    logic       snd;
  } exp_t;

  logic       clock;
  logic       reset;
  logic [3:0] key;
  logic [3:0] alarm_time;
  logic [3:0] current_time;
  logic       show_alarm;
  logic       show_new_time;
  logic [7:0] display_time;
  logic       sound_alarm;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_bad;

  lcd_display_driver dut (
    .clock        (clock),
    .reset        (reset),
    .key          (key),
    .alarm_time   (alarm_time),
    .current_time (current_time),
    .show_alarm   (show_alarm),
    .show_new_time(show_new_time),
    .display_time (display_time),
    .sound_alarm  (sound_alarm)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: what the LCD should show for a digit.
  function automatic logic [7:0] ref_char(input int d);
    if (d < 10) return 8'(48 + d);
    return 8'h45;
  endfunction

  task automatic check(input string nm, input logic [7:0] act_d, input logic act_s,
                       input logic [7:0] exp_d, input logic exp_s);
    n_cmp++;
    if (act_d !== exp_d || act_s !== exp_s) begin
      n_bad++;
      $display("FAIL %s: got display=%h sound=%b, want display=%h sound=%b",
               nm, act_d, act_s, exp_d, exp_s);
    end
  endtask

  // Drive one set of inputs at the falling edge; a short glitch value is
  // applied first so only the settled value should be sampled. The model
  // result is queued for the monitor.
  task automatic drive(input string nm, input int k, input int a, input int c,
                       input bit sa, input bit sn);
    exp_t e;
    int   sel;
    @(negedge clock);
    key           = 4'($urandom_range(0, 15));
    alarm_time    = 4'($urandom_range(0, 15));
    current_time  = 4'($urandom_range(0, 15));
    show_alarm    = 1'($urandom_range(0, 1));
    show_new_time = 1'($urandom_range(0, 1));
    #1;
    key           = 4'(k);
    alarm_time    = 4'(a);
    current_time  = 4'(c);
    show_alarm    = sa;
    show_new_time = sn;
    if (sn)      sel = k;
    else if (sa) sel = a;
    else         sel = c;
    e.name = nm;
    if (reset) begin
      e.disp = ref_char(sel);
      e.snd  = (a == c) && (a < 10);
    end else begin
      e.disp = 8'h20;
      e.snd  = 1'b0;
    end
    sb_q.push_back(e);
  endtask

  // Monitor: one registered result per rising edge, sampled just after it.
  always begin
    exp_t e;
    @(posedge clock);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, display_time, sound_alarm, e.disp, e.snd);
    end
  end

  initial begin
    int wait_cyc;
    n_cmp = 0;
    n_bad = 0;
    key = 4'd0; alarm_time = 4'd0; current_time = 4'd0;
    show_alarm = 1'b0; show_new_time = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    key = 4'd5; alarm_time = 4'd5; current_time = 4'd5; show_alarm = 1'b1;
    #1;
    check("reset_async", display_time, sound_alarm, 8'h20, 1'b0);
    // Held while low across edges even though alarm==cur.
    drive("reset_hold", 5, 5, 5, 1'b1, 1'b0);
    drive("reset_hold2", 3, 3, 3, 1'b0, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    drive("release_first", 6, 4, 7, 1'b0, 1'b0);
    drive("sel_cur", 6, 4, 7, 1'b0, 1'b0);
    drive("sel_alarm", 6, 3, 11, 1'b1, 1'b0);
    drive("sel_key", 2, 11, 9, 1'b0, 1'b1);
    drive("sel_priority", 2, 11, 9, 1'b1, 1'b1);
    drive("match", 2, 9, 9, 1'b0, 1'b1);
    drive("match_nonbcd", 2, 12, 12, 1'b0, 1'b0);
    drive("match_zero", 1, 0, 0, 1'b1, 1'b0);
    for (int d = 10; d < 16; d++) drive($sformatf("err_cur%0d", d), 0, 1, d, 1'b0, 1'b0);
    for (int d = 0; d < 10; d++) begin
      drive($sformatf("sweep_cur%0d", d), 15, 14, d, 1'b0, 1'b0);
      if (d == 5) begin
        // Let the queued result be checked, then pulse reset between edges.
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("reset_midsweep", display_time, sound_alarm, 8'h20, 1'b0);
        @(negedge clock);
        reset = 1'b1;
      end
    end
    for (int i = 0; i < 300; i++) begin
      int a, c;
      a = $urandom_range(0, 15);
      c = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 15);
      drive("random", $urandom_range(0, 15), a, c,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clock);
      wait_cyc++;
    end
    @(negedge clock);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d results pending, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
